bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one valid/ready peripheral bus slave (e.g. a GPIO/input
//   register block) between N_MASTERS requesters (CPU, DMA, debug). Locks grant for a whole
//   transaction, inserts one idle gap so the slave's registered ready drops, and aborts
//   hung transactions with a timeout error response.
// PARAMETERS
//   N_MASTERS  2    number of requesting masters, 2..8
//   TIMEOUT    255  max BUSY cycles before forced error completion; 0 = timeout disabled
//   ERR_RDATA  32'hDEAD_BEEF  rdata returned to the master on timeout
// PORTS
//   clk          in   1             clock
//   resetn       in   1             reset, synchronous, active-low
//   m_valid      in   N_MASTERS     per-master request valid
//   m_ready      out  N_MASTERS     per-master completion, 1-cycle pulse
//   m_wstrb      in   4*N_MASTERS   per-master byte strobes (master i at [4i+:4]); 0 = read
//   m_addr       in   32*N_MASTERS  per-master address (master i at [32i+:32])
//   m_wdata      in   32*N_MASTERS  per-master write data
//   m_rdata      out  32            read data, shared by all masters, valid with m_ready
//   s_valid      out  1             slave request valid
//   s_ready      in   1             slave completion
//   s_wstrb      out  4             slave byte strobes
//   s_addr       out  32            slave address
//   s_wdata      out  32            slave write data
//   s_rdata      in   32            slave read data
//   grant        out  N_MASTERS     one-hot current owner (0 when no owner)
//   timeout_err  out  1             sticky: set on any timeout completion
//   err_clr      in   1             clears timeout_err (set wins if same cycle)
// BEHAVIOUR
//   - Reset: state=IDLE, grant=0, s_valid=0, m_ready=0, timeout_err=0, cnt=0,
//     last=N_MASTERS-1 (master 0 wins first arbitration).
//   - FSM IDLE -> BUSY -> GAP -> IDLE.
//   - IDLE: s_valid=0. If any m_valid: winner = first i with m_valid[i] scanning
//     last+1, last+2, ... modulo N_MASTERS; grant<=onehot(winner), last<=winner, cnt<=0,
//     -> BUSY. Else stay.
//   - BUSY: s_valid=1; s_wstrb/s_addr/s_wdata combinationally muxed from granted master.
//     cnt increments each BUSY cycle.
//       * s_ready=1: m_ready[g]=1 this cycle, m_rdata=s_rdata; -> GAP.
//       * else if TIMEOUT!=0 and cnt==TIMEOUT-1: m_ready[g]=1, m_rdata=ERR_RDATA,
//         timeout_err<=1; -> GAP. s_ready wins if both same cycle.
//       * else if m_valid[g]=0 (protocol violation): abort, no m_ready; -> GAP.
//   - GAP: s_valid=0, grant<=0, m_ready=0, s_ready ignored; -> IDLE. Guarantees slave
//     with ready<=valid sees valid low before next request. Minimum issue rate: one
//     transaction per 3 cycles + slave latency.
//   - m_ready is 0 outside BUSY regardless of s_ready; m_rdata = s_rdata when no timeout.
//   - Requests from non-granted masters are held off (m_ready=0); they keep valid asserted.
//   - Requests arriving during BUSY/GAP are arbitrated in the next IDLE, never preempt.
//   - Reset mid-BUSY: s_valid drops next cycle, no m_ready issued, pointer returns to N-1.
//   - cnt width = clog2(TIMEOUT+1); saturates, never wraps while in BUSY.
// TESTING
//   1 Reset, m_valid=2'b01, addr0=0x0, slave ready 1 cycle after valid -> s_valid seen
//     cycle 2, m_ready=2'b01 cycle 3, m_rdata=slave data, s_valid=0 in GAP.
//   2 Both masters valid continuously -> grants alternate 0,1,0,1; never same master twice
//     while other waits; each m_ready one cycle wide.
//   3 Master 1 write, wstrb=4'hF, addr=0x4, wdata=0x1234_5678 -> s_* equal those values
//     for every BUSY cycle; master 0 raises valid mid-BUSY and is served only after GAP.
//   4 TIMEOUT=8, slave never ready -> m_ready pulse after exactly 8 BUSY cycles,
//     m_rdata=0xDEAD_BEEF, timeout_err=1 until err_clr; err_clr+new timeout same cycle -> 1.
//   5 Granted master drops valid in BUSY -> no m_ready, GAP, IDLE, pointer advanced.
//   6 resetn low during BUSY -> next cycle s_valid=0, grant=0, m_ready=0; first grant
//     after reset goes to master 0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready bus slave between N_MASTERS requesters.
// Grant is held for a whole transaction, followed by one idle gap; hung transfers time out.
module bus_rr_arbiter #(
    parameter int          N_MASTERS = 2,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_MASTERS-1:0]     m_valid_i,
    output logic [N_MASTERS-1:0]     m_ready_o,
    input  logic [4*N_MASTERS-1:0]   m_wstrb_i,
    input  logic [32*N_MASTERS-1:0]  m_addr_i,
    input  logic [32*N_MASTERS-1:0]  m_wdata_i,
    output logic [31:0]              m_rdata_o,
    output logic                     s_valid_o,
    input  logic                     s_ready_i,
    output logic [3:0]               s_wstrb_o,
    output logic [31:0]              s_addr_o,
    output logic [31:0]              s_wdata_o,
    input  logic [31:0]              s_rdata_i,
    output logic [N_MASTERS-1:0]     grant_o,
    output logic                     timeout_err_o,
    input  logic                     err_clr_i
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TERM = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     own_q, own_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 terr_q, terr_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    int                   cand;

    // Scan last+1, last+2, ... so the most recent owner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = int'(last_q) + k;
            if (cand >= N_MASTERS) begin
                cand = cand - N_MASTERS;
            end
            if (!win_found && m_valid_i[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        s_wstrb_o = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (own_q == IDX_W'(i)) begin
                s_wstrb_o = m_wstrb_i[4*i +: 4];
                s_addr_o  = m_addr_i[32*i +: 32];
                s_wdata_o = m_wdata_i[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            own_q   <= '0;
            last_q  <= IDX_LAST;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        own_d     = own_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        s_valid_o = 1'b0;
        m_ready_o = '0;
        m_rdata_o = s_rdata_i;

        if (err_clr_i) begin
            terr_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    own_d            = win_idx;
                    last_d           = win_idx;
                    cnt_d            = '0;
                    state_d          = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_valid_o = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (s_ready_i) begin
                    m_ready_o[own_q] = 1'b1;
                    state_d          = ST_GAP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_TERM)) begin
                    m_ready_o[own_q] = 1'b1;
                    m_rdata_o        = ERR_RDATA;
                    terr_d           = 1'b1;
                    state_d          = ST_GAP;
                end else if (!m_valid_i[own_q]) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_o       = grant_q;
    assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios then random traffic, all checked every cycle
// against a transaction-phase reference model.
module tb_bus_rr_arbiter;
    localparam int          N   = 2;
    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    m_valid, m_ready;
    logic [4*N-1:0]  m_wstrb;
    logic [32*N-1:0] m_addr, m_wdata;
    logic [31:0]     m_rdata;
    logic            s_valid, s_ready;
    logic [3:0]      s_wstrb;
    logic [31:0]     s_addr, s_wdata, s_rdata;
    logic [N-1:0]    grant;
    logic            timeout_err, err_clr;

    bus_rr_arbiter #(.N_MASTERS(N), .TIMEOUT(TMO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid_i(m_valid), .m_ready_o(m_ready), .m_wstrb_i(m_wstrb),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
        .s_valid_o(s_valid), .s_ready_i(s_ready), .s_wstrb_o(s_wstrb),
        .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata),
        .grant_o(grant), .timeout_err_o(timeout_err), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 idle, 1 transfer in flight, 2 gap
    int          ph, own, last, bc, slat, lat_fixed;
    logic        terr;
    logic [N-1:0] last_rdy, pend;
    logic [31:0] addr_a[N], wdata_a[N];
    logic [3:0]  wstrb_a[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_rdy, exp_gnt;
        logic [31:0]  exp_rd;
        logic         tmo, found;
        for (int i = 0; i < N; i++) begin
            m_addr[32*i +: 32]  = addr_a[i];
            m_wdata[32*i +: 32] = wdata_a[i];
            m_wstrb[4*i +: 4]   = wstrb_a[i];
        end
        s_ready = (ph == 1) ? (bc == slat) : ($urandom_range(0, 3) == 0);
        if (!resetn) s_ready = 1'b0;
        s_rdata = $urandom;
        #1;
        exp_gnt = '0;
        if (ph != 0) exp_gnt[own] = 1'b1;
        exp_rdy = '0;
        exp_rd  = s_rdata;
        tmo     = 1'b0;
        if (ph == 1) begin
            if (s_ready) begin
                exp_rdy[own] = 1'b1;
            end else if (bc + 1 == TMO) begin
                exp_rdy[own] = 1'b1;
                exp_rd       = ERR;
                tmo          = 1'b1;
            end
        end
        chk("s_valid", 32'(s_valid), 32'(ph == 1));
        chk("grant", 32'(grant), 32'(exp_gnt));
        chk("m_ready", 32'(m_ready), 32'(exp_rdy));
        chk("timeout_err", 32'(timeout_err), 32'(terr));
        if (ph == 1) begin
            chk("s_addr", s_addr, addr_a[own]);
            chk("s_wdata", s_wdata, wdata_a[own]);
            chk("s_wstrb", 32'(s_wstrb), 32'(wstrb_a[own]));
        end
        if (exp_rdy != '0) chk("m_rdata", m_rdata, exp_rd);
        last_rdy = exp_rdy;
        @(posedge clk);
        if (!resetn) begin
            ph = 0; last = N - 1; terr = 1'b0; bc = 0; last_rdy = '0;
        end else begin
            if (tmo) terr = 1'b1;
            else if (err_clr) terr = 1'b0;
            if (ph == 0) begin
                if (m_valid != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && m_valid[(last + k) % N]) begin
                            own = (last + k) % N;
                            found = 1'b1;
                        end
                    end
                    last = own; bc = 0; ph = 1;
                    if (lat_fixed >= 0) slat = lat_fixed;
                    else slat = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
                end
            end else if (ph == 1) begin
                bc++;
                if (exp_rdy != '0 || !m_valid[own]) ph = 2;
            end else begin
                ph = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        ph = 0; own = 0; last = N - 1; bc = 0; slat = 0; terr = 1'b0; lat_fixed = 1;
        last_rdy = '0; pend = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0; wdata_a[i] = '0; wstrb_a[i] = '0;
        end
        resetn = 1'b0; m_valid = '0; err_clr = 1'b0; s_ready = 1'b0; s_rdata = '0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Single read from master 0, slave answers one cycle after valid
        tick();
        m_valid = 2'b01; addr_a[0] = 32'h0;
        repeat (3) tick();
        m_valid = 2'b00;
        repeat (2) tick();

        // Both masters requesting continuously
        lat_fixed = 0;
        m_valid = 2'b11;
        repeat (15) tick();
        m_valid = 2'b00;
        repeat (3) tick();

        // Master 1 write; master 0 arrives mid-transfer
        lat_fixed = 3;
        wstrb_a[1] = 4'hF; addr_a[1] = 32'h4; wdata_a[1] = 32'h1234_5678;
        m_valid = 2'b10;
        repeat (3) tick();
        m_valid = 2'b11;
        repeat (3) tick();
        m_valid = 2'b01;
        repeat (6) tick();
        m_valid = 2'b00;
        repeat (2) tick();

        // Timeout, sticky flag, clear, and set-wins-over-clear
        lat_fixed = 100;
        m_valid = 2'b01;
        repeat (10) tick();
        m_valid = 2'b00;
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        tick();
        chk("tmo_cleared", 32'(timeout_err), 32'd0);
        m_valid = 2'b01;
        repeat (8) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        m_valid = 2'b00;
        chk("tmo_set_wins", 32'(timeout_err), 32'd1);
        repeat (2) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Granted master withdraws its request mid-transfer
        lat_fixed = 5;
        m_valid = 2'b01;
        repeat (2) tick();
        m_valid = 2'b00;
        repeat (3) tick();
        m_valid = 2'b11;
        tick();
        chk("ptr_after_abort", 32'(grant), 32'd2);
        m_valid = 2'b00;
        repeat (4) tick();

        // Reset in the middle of a transfer
        m_valid = 2'b10;
        repeat (3) tick();
        resetn = 1'b0; tick(); resetn = 1'b1;
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        m_valid = 2'b11;
        tick();
        chk("first_after_rst", 32'(grant), 32'd1);
        m_valid = 2'b00;
        repeat (8) tick();

        // Random traffic
        lat_fixed = -1;
        pend = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]    = 1'b1;
                    addr_a[i]  = $urandom;
                    wdata_a[i] = $urandom;
                    wstrb_a[i] = 4'($urandom_range(0, 15));
                end
                m_valid[i] = pend[i];
                if (ph == 1 && own == i && $urandom_range(0, 39) == 0) m_valid[i] = 1'b0;
            end
            err_clr = ($urandom_range(0, 15) == 0);
            resetn  = ($urandom_range(0, 299) != 0);
            tick();
            pend = pend & ~last_rdy;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
